game_pc_packet_rx: RTL and testbench

//  Receive-side decoder for the 14-byte game-state packet sent over RS-232 by the game/PC link.

---
 rtl/game_pc_packet_rx.sv | 176 +++++++++++++++++
 tb/tb_game_pc_packet_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_pc_packet_rx.sv
// Receive-side decoder for the 14-byte game-state packet: hunts for the header, collects
// 13 body bytes, validates reserved bits and commits all game fields atomically.
//   state  | meaning
//   S_HUNT | waiting for HEADER byte
//   S_BODY | collecting body bytes 1..13 under inter-byte timeout
module game_pc_packet_rx #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] HEADER         = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_err,
  output logic        o_frame_valid,
  output logic        o_err_format,
  output logic        o_err_timeout,
  output logic        o_err_line,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [1:0]  o_winner,
  output logic [3:0]  o_state,
  output logic        o_playerA,
  output logic        o_playerB,
  output logic        o_saw_active,
  output logic        o_reverse_active,
  output logic        o_handcuff_active,
  output logic        o_bullet_report_valid,
  output logic        o_bullet_report,
  output logic [2:0]  o_report_idx,
  output logic [2:0]  o_hp_p0,
  output logic [2:0]  o_hp_p1,
  output logic [3:0]  o_total_bullet,
  output logic [3:0]  o_total_bullet_remaining,
  output logic [2:0]  o_bullet_filled,
  output logic [2:0]  o_bullet_empty,
  output logic [3:0]  o_bullet_bitmap_ptr,
  output logic [7:0]  o_bullet_bitmap,
  output logic [3:0]  o_item_column_p0_0,
  output logic [3:0]  o_item_column_p0_1,
  output logic [3:0]  o_item_column_p0_2,
  output logic [3:0]  o_item_column_p0_3,
  output logic [3:0]  o_item_column_p0_4,
  output logic [3:0]  o_item_column_p0_5,
  output logic [3:0]  o_item_column_p1_0,
  output logic [3:0]  o_item_column_p1_1,
  output logic [3:0]  o_item_column_p1_2,
  output logic [3:0]  o_item_column_p1_3,
  output logic [3:0]  o_item_column_p1_4,
  output logic [3:0]  o_item_column_p1_5
);

  localparam int             CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAST_IDX  = 4'd13;

  typedef enum logic {S_HUNT = 1'b0, S_BODY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      shadow_q [1:12];
  logic [95:0]     fields_q, fields_d;
  logic [15:0]     frame_cnt_q;
  logic            fv_q, fv_d, fmt_q, fmt_d, to_q, to_d, line_q, line_d;
  logic            shadow_we, commit_en, rsv_bad;

  assign rsv_bad = |{shadow_q[3][4], shadow_q[3][0], shadow_q[5][4], shadow_q[5][0],
                     shadow_q[6][3:0]};

  // Reserved bits are dropped here; the last byte comes straight from the input.
  assign fields_d = {shadow_q[1], shadow_q[2],
                     shadow_q[3][7:5], shadow_q[3][3:1],
                     shadow_q[4],
                     shadow_q[5][7:5], shadow_q[5][3:1],
                     shadow_q[6][7:4], shadow_q[7],
                     shadow_q[8], shadow_q[9], shadow_q[10], shadow_q[11], shadow_q[12],
                     i_rx_data};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shadow_we = 1'b0;
    commit_en = 1'b0;
    fv_d      = 1'b0;
    fmt_d     = 1'b0;
    to_d      = 1'b0;
    line_d    = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (i_rx_valid && i_rx_data == HEADER) begin
          state_d = S_BODY;
          idx_d   = 4'd1;
          cnt_d   = '0;
        end
      end
      S_BODY: begin
        if (i_rx_err) begin
          state_d = S_HUNT;
          idx_d   = 4'd0;
          cnt_d   = '0;
          line_d  = 1'b1;
        end else if (i_rx_valid) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d   = S_HUNT;
            idx_d     = 4'd0;
            fmt_d     = rsv_bad;
            fv_d      = !rsv_bad;
            commit_en = !rsv_bad;
          end else begin
            shadow_we = 1'b1;
            idx_d     = idx_q + 4'd1;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_HUNT;
          idx_d   = 4'd0;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      fields_q    <= '0;
      frame_cnt_q <= 16'd0;
      fv_q        <= 1'b0;
      fmt_q       <= 1'b0;
      to_q        <= 1'b0;
      line_q      <= 1'b0;
      for (int i = 1; i <= 12; i++) shadow_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fmt_q   <= fmt_d;
      to_q    <= to_d;
      line_q  <= line_d;
      if (shadow_we) shadow_q[idx_q] <= i_rx_data;
      if (commit_en) begin
        fields_q    <= fields_d;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign o_frame_valid = fv_q;
  assign o_err_format  = fmt_q;
  assign o_err_timeout = to_q;
  assign o_err_line    = line_q;
  assign o_busy        = (state_q == S_BODY);
  assign o_frame_cnt   = frame_cnt_q;

  assign {o_winner, o_state, o_playerA, o_playerB,
          o_saw_active, o_reverse_active, o_handcuff_active,
          o_bullet_report_valid, o_bullet_report, o_report_idx,
          o_hp_p0, o_hp_p1,
          o_total_bullet, o_total_bullet_remaining,
          o_bullet_filled, o_bullet_empty,
          o_bullet_bitmap_ptr, o_bullet_bitmap,
          o_item_column_p0_0, o_item_column_p0_1, o_item_column_p0_2,
          o_item_column_p0_3, o_item_column_p0_4, o_item_column_p0_5,
          o_item_column_p1_0, o_item_column_p1_1, o_item_column_p1_2,
          o_item_column_p1_3, o_item_column_p1_4, o_item_column_p1_5} = fields_q;

endmodule

// File: tb/tb_game_pc_packet_rx.sv
// Bench for game_pc_packet_rx: frame scenario table, hand-written corner sequences and
// random byte streams, all checked every cycle against a queue-based packet model.
module tb_game_pc_packet_rx;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0, rx_err = 1'b0;
  logic [7:0] rx_data = 8'd0;

  logic fv, fmt, tmo, line, busy;
  logic [15:0] fcnt;
  logic [1:0] winner; logic [3:0] gstate; logic pa, pb;
  logic saw, rev, cuff, rv, rep; logic [2:0] ridx;
  logic [2:0] hp0, hp1; logic [3:0] tot, rem; logic [2:0] filled, empty;
  logic [3:0] ptr; logic [7:0] bitmap;
  logic [3:0] c00, c01, c02, c03, c04, c05, c10, c11, c12, c13, c14, c15;

  game_pc_packet_rx #(.TIMEOUT_CYCLES(T), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_rx_err(rx_err),
    .o_frame_valid(fv), .o_err_format(fmt), .o_err_timeout(tmo), .o_err_line(line),
    .o_busy(busy), .o_frame_cnt(fcnt),
    .o_winner(winner), .o_state(gstate), .o_playerA(pa), .o_playerB(pb),
    .o_saw_active(saw), .o_reverse_active(rev), .o_handcuff_active(cuff),
    .o_bullet_report_valid(rv), .o_bullet_report(rep), .o_report_idx(ridx),
    .o_hp_p0(hp0), .o_hp_p1(hp1), .o_total_bullet(tot), .o_total_bullet_remaining(rem),
    .o_bullet_filled(filled), .o_bullet_empty(empty),
    .o_bullet_bitmap_ptr(ptr), .o_bullet_bitmap(bitmap),
    .o_item_column_p0_0(c00), .o_item_column_p0_1(c01), .o_item_column_p0_2(c02),
    .o_item_column_p0_3(c03), .o_item_column_p0_4(c04), .o_item_column_p0_5(c05),
    .o_item_column_p1_0(c10), .o_item_column_p1_1(c11), .o_item_column_p1_2(c12),
    .o_item_column_p1_3(c13), .o_item_column_p1_4(c14), .o_item_column_p1_5(c15));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int t_fv = 0, t_fmt = 0, t_to = 0, t_line = 0;

  // Reference model: packet-level view of the receiver.
  logic       m_hunt;
  logic [7:0] m_body[$];
  int         m_idle;
  logic [7:0] m_f[13];
  logic [15:0] m_cnt;
  logic       e_fv, e_fmt, e_to, e_line;

  function automatic void model_reset();
    m_hunt = 1'b1; m_body.delete(); m_idle = 0; m_cnt = 16'd0;
    for (int i = 0; i < 13; i++) m_f[i] = 8'd0;
    e_fv = 0; e_fmt = 0; e_to = 0; e_line = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d, input logic e);
    e_fv = 0; e_fmt = 0; e_to = 0; e_line = 0;
    if (m_hunt) begin
      if (v && d == 8'hA5) begin m_hunt = 0; m_body.delete(); m_idle = 0; end
    end else if (e) begin
      e_line = 1; m_hunt = 1;
    end else if (v) begin
      m_body.push_back(d); m_idle = 0;
      if (m_body.size() == 13) begin
        if (((m_body[2] | m_body[4]) & 8'h11) != 0 || (m_body[5] & 8'h0F) != 0) e_fmt = 1;
        else begin
          for (int i = 0; i < 13; i++) m_f[i] = m_body[i];
          m_cnt = m_cnt + 16'd1; e_fv = 1;
        end
        m_hunt = 1;
      end
    end else begin
      m_idle++;
      if (m_idle == T) begin e_to = 1; m_hunt = 1; end
    end
  endfunction

  function automatic logic [127:0] model_vec();
    logic [103:0] b = '0;
    for (int i = 0; i < 13; i++) b[103-8*i -: 8] = m_f[i];
    return {3'b0, e_fv, e_fmt, e_to, e_line, !m_hunt, m_cnt, b};
  endfunction

  function automatic logic [127:0] dut_vec();
    logic [103:0] b;
    b = {winner, gstate, pa, pb, saw, rev, cuff, rv, rep, ridx,
         hp0, 1'b0, hp1, 1'b0, tot, rem, filled, 1'b0, empty, 1'b0, ptr, 4'b0, bitmap,
         c00, c01, c02, c03, c04, c05, c10, c11, c12, c13, c14, c15};
    return {3'b0, fv, fmt, tmo, line, busy, fcnt, b};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic e);
    rx_valid = v; rx_data = d; rx_err = e;
    model_step(v, d, e);
    @(posedge clk); #1;
    check("cycle", dut_vec(), model_vec());
    t_fv += int'(fv); t_fmt += int'(fmt); t_to += int'(tmo); t_line += int'(line);
    rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_vec(), model_vec());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] fbyte(input logic [111:0] f, input int i);
    return f[111-8*i -: 8];
  endfunction

  task automatic send_frame(input logic [111:0] f);
    for (int i = 0; i < 14; i++) cyc(1'b1, fbyte(f, i), 1'b0);
  endtask

  task automatic clr_tally();
    t_fv = 0; t_fmt = 0; t_to = 0; t_line = 0;
  endtask

  typedef struct {
    logic [111:0] bytes;
    int           err_at;
    logic [3:0]   exp_pulse;  // {frame_valid, err_format, err_timeout, err_line}
    logic [15:0]  exp_cnt;
  } scen_t;

  localparam logic [111:0] F1   = 112'hA5_95_E5_A4_73_48_30_C3_12_34_56_78_9A_BC;
  localparam logic [111:0] F_R3 = 112'hA5_95_E5_A5_73_48_30_C3_12_34_56_78_9A_BC;
  localparam logic [111:0] F_B7 = 112'hA5_95_E5_A4_73_48_30_A5_12_34_56_78_9A_BC;
  localparam logic [111:0] F_R6 = 112'hA5_95_E5_A4_73_48_31_C3_12_34_56_78_9A_BC;
  localparam logic [111:0] F_R5 = 112'hA5_95_E5_A4_73_58_30_C3_12_34_56_78_9A_BC;

  scen_t tbl[7];

  initial begin
    tbl[0] = '{F1,   0, 4'b1000, 16'd1};
    tbl[1] = '{F_R3, 0, 4'b0100, 16'd1};
    tbl[2] = '{F_B7, 0, 4'b1000, 16'd2};
    tbl[3] = '{F1,   9, 4'b0001, 16'd2};
    tbl[4] = '{F_R6, 0, 4'b0100, 16'd2};
    tbl[5] = '{F_R5, 0, 4'b0100, 16'd2};
    tbl[6] = '{F1,   0, 4'b1000, 16'd3};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < 14; i++) begin
        if (tbl[s].err_at != 0 && i == tbl[s].err_at) begin
          cyc(1'b0, 8'h00, 1'b1);
          break;
        end
        cyc(1'b1, fbyte(tbl[s].bytes, i), 1'b0);
      end
      check("scen_pulse", {124'd0, fv, fmt, tmo, line}, {124'd0, tbl[s].exp_pulse});
      check("scen_cnt", {112'd0, fcnt}, {112'd0, tbl[s].exp_cnt});
      if (s == 0) begin
        check("f1_fields",
              {winner, gstate, pa, pb, saw, rev, cuff, rv, rep, ridx, hp0, hp1,
               tot, rem, filled, empty, ptr, bitmap},
              {2'd2, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd5, 3'd2,
               4'd7, 4'd3, 3'd2, 3'd4, 4'd3, 8'hC3});
        check("f1_columns", {c00, c01, c02, c03, c04, c05, c10, c11, c12, c13, c14, c15},
              48'h123456789ABC);
      end
      if (s == 2) check("bitmap_a5", {120'd0, bitmap}, {120'd0, 8'hA5});
    end

    // Garbage ahead of a frame gives exactly one commit.
    clr_tally();
    cyc(1'b1, 8'h00, 1'b0); cyc(1'b1, 8'h12, 1'b0); cyc(1'b1, 8'hFF, 1'b0);
    send_frame(F1);
    check("garbage_commits", t_fv, 1);
    check("garbage_errors", t_fmt + t_to + t_line, 0);

    // Inter-byte timeout, then recovery.
    clr_tally();
    for (int i = 0; i < 6; i++) cyc(1'b1, fbyte(F1, i), 1'b0);
    idle(T);
    check("timeout_pulse", {127'd0, tmo}, 128'd1);
    idle(3);
    check("timeout_once", t_to, 1);
    check("timeout_busy", {127'd0, busy}, 128'd0);
    send_frame(F1);
    check("after_timeout_commit", t_fv, 1);

    // Byte on the limit cycle wins over the timeout.
    clr_tally();
    cyc(1'b1, 8'hA5, 1'b0);
    idle(T - 1);
    for (int i = 1; i < 14; i++) cyc(1'b1, fbyte(F1, i), 1'b0);
    check("limit_no_timeout", t_to, 0);
    check("limit_commit", t_fv, 1);

    // rx_err beats a simultaneous byte in the body; ignored while hunting.
    clr_tally();
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hA5, 1'b1);
    for (int i = 1; i < 4; i++) cyc(1'b1, fbyte(F1, i), 1'b0);
    cyc(1'b1, 8'h11, 1'b1);
    check("line_priority", {127'd0, line}, 128'd1);
    check("line_once", t_line, 1);

    // Reset mid-frame, then a clean frame.
    for (int i = 0; i < 7; i++) cyc(1'b1, fbyte(F1, i), 1'b0);
    do_reset();
    send_frame(F1);
    check("post_reset_cnt", {112'd0, fcnt}, 128'd1);
    check("post_reset_cols", {c00, c01, c02, c03, c04, c05, c10, c11, c12, c13, c14, c15},
          48'h123456789ABC);

    // Random frames with gaps, corruption, line errors and timeouts.
    for (int f = 0; f < 150; f++) begin
      int bad_byte;
      repeat ($urandom_range(0, 2)) cyc(1'b1, 8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
      cyc(1'b1, 8'hA5, 1'b0);
      bad_byte = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      for (int k = 1; k < 14; k++) begin
        int g;
        logic [7:0] b;
        int r;
        g = $urandom_range(0, 3);
        r = $urandom_range(0, 39);
        if (r == 0) g = T;
        else if (r == 1) g = T - 1;
        idle(g);
        b = 8'($urandom_range(0, 255));
        if (k == 3 && bad_byte != 0) b = b & 8'hEE;
        if (k == 5 && bad_byte != 1) b = b & 8'hEE;
        if (k == 6 && bad_byte != 2) b = b & 8'hF0;
        cyc(1'b1, b, ($urandom_range(0, 59) == 0));
      end
    end
    idle(T + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
